// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package mult_arb_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Pass 0 scans [ptr, NUM_REQ), pass 1 wraps around to [0, ptr).
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any && valid[i] && ((p == 0) == (i >= 32'(ptr)))) begin
          grant[i] = 1'b1;
          idx      = IDX_W'(i);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one iterative 32x32 signed multiplier among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned DRAIN_CYC = 33,
  parameter int unsigned TIMEOUT   = 40
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_op1,
  input  logic [NUM_REQ*OP_W-1:0] req_op2,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    rsp_err,
  output logic                    mult_begin,
  output logic [OP_W-1:0]         mult_op1,
  output logic [OP_W-1:0]         mult_op2,
  input  logic [PROD_W-1:0]       mult_product,
  input  logic                    mult_end
);

  localparam int unsigned DCW = $clog2(DRAIN_CYC + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || DRAIN_CYC < 1 || TIMEOUT < 1)
  begin : g_param_check
    $error("mult_share_arbiter: illegal parameter set");
  end

  state_t             state;
  logic [DCW-1:0]     drain_cnt;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [OP_W-1:0]    sel_op1;
  logic [OP_W-1:0]    sel_op2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_op1 = req_op1[i*OP_W +: OP_W];
        sel_op2 = req_op2[i*OP_W +: OP_W];
      end
    end
  end

  // The accept handshake must land in the same cycle req_valid is seen.
  assign req_ready = (state == ST_IDLE) ? gnt_onehot : '0;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  logic [WCW-1:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_DRAIN;
      drain_cnt   <= '0;
      rr_ptr      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      mult_begin  <= 1'b0;
      mult_op1    <= '0;
      mult_op2    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      rsp_err     <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_DRAIN: begin
          mult_begin <= 1'b0;
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        ST_IDLE: begin
          if (gnt_any) begin
            rsp_id <= gnt_idx;
            rr_ptr <= ID_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
`ifdef MULT_ARB_TIMEOUT_EN
            rsp_err <= 1'b0;
`endif
            // A zero operand never completes in the multiplier; answer directly.
            if (sel_op1 == '0 || sel_op2 == '0) begin
              rsp_product <= '0;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end else begin
              mult_op1   <= sel_op1;
              mult_op2   <= sel_op2;
              mult_begin <= 1'b1;
              state      <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          mult_begin <= 1'b0;
          state      <= ST_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end
        ST_WAIT: begin
          if (mult_end) begin
            rsp_product <= mult_product;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            // After a timeout the multiplier state is unknown; flush it again.
            state     <= rsp_err ? ST_DRAIN : ST_IDLE;
`else
            state     <= ST_IDLE;
`endif
          end
        end
        default: state <= ST_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier stub.
module tb_mult_share_arbiter;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_op1 = '0;
  logic [127:0] req_op2 = '0;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_product;
  logic         rsp_err;
  logic         mult_begin;
  logic [31:0]  mult_op1;
  logic [31:0]  mult_op2;
  logic [63:0]  mult_product = '0;
  logic         mult_end = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mult_share_arbiter #(
    .NUM_REQ   (4),
    .ID_W      (2),
    .DRAIN_CYC (33),
    .TIMEOUT   (40)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_product  (rsp_product),
    .rsp_err      (rsp_err),
    .mult_begin   (mult_begin),
    .mult_op1     (mult_op1),
    .mult_op2     (mult_op2),
    .mult_product (mult_product),
    .mult_end     (mult_end)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: mult_end two cycles after the cycle mult_begin is seen.
  int   stub_cnt = 0;
  logic stub_dead = 1'b0;
  int   begin_cnt = 0;
  always @(posedge clk) begin
    if (mult_begin) begin
      begin_cnt    <= begin_cnt + 1;
      stub_cnt     <= 2;
      mult_product <= {{32{mult_op1[31]}}, mult_op1} * {{32{mult_op2[31]}}, mult_op2};
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
    mult_end <= (stub_cnt == 1) && !mult_begin && !stub_dead;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [63:0] prod;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (resetn && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d, none outstanding", rsp_id);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_product", rsp_product, mon_e.prod);
        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        if (mon_e.lat != 0) chk("rsp_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        err;
    int          lat;
    int          nb;
  } vec_t;

  vec_t        tbl[9];
  logic [31:0] hop1[4];
  logic [31:0] hop2[4];
  logic [63:0] hprod[4];
  int          rel;

  task automatic wait_empty();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (sb.size() == 0) done = 1;
      else @(negedge clk);
    end
    if (!done) fail_now("rsp_wait");
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_id", 64'(rsp_id), 64'h0);
    chk("rst_rsp_product", rsp_product, 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    chk("rst_mult_begin", 64'(mult_begin), 64'h0);
    chk("rst_mult_op1", 64'(mult_op1), 64'h0);
    chk("rst_mult_op2", 64'(mult_op2), 64'h0);
  endtask

  task automatic run_vec(input vec_t v, output int acc);
    bit   got = 0;
    int   b0;
    exp_t e;
    acc = -1;
    @(negedge clk);
    req_op1[v.id*32 +: 32] = v.a;
    req_op2[v.id*32 +: 32] = v.b;
    req_valid[v.id] = 1'b1;
    b0 = begin_cnt;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (req_ready[v.id]) begin
        got    = 1;
        acc    = cyc;
        e.id   = 2'(v.id);
        e.prod = v.prod;
        e.err  = v.err;
        e.acc  = cyc;
        e.lat  = v.lat;
        sb.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) fail_now("grant_wait");
    @(posedge clk);
    #1;
    req_valid[v.id] = 1'b0;
    wait_empty();
    chk("begin_count", 64'(begin_cnt - b0), 64'(v.nb));
  endtask

  task automatic grant_seq(input logic [3:0] mask, input int n, input int order[5]);
    int   g = 0;
    exp_t e;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      req_op1[r*32 +: 32] = hop1[r];
      req_op2[r*32 +: 32] = hop2[r];
    end
    req_valid = mask;
    for (int i = 0; i < 400 && g < n; i++) begin
      #1;
      if (req_ready != 4'b0) begin
        chk("grant_order", 64'(req_ready), 64'(4'b0001 << order[g]));
        e.id   = 2'(order[g]);
        e.prod = hprod[order[g]];
        e.err  = 1'b0;
        e.acc  = cyc;
        e.lat  = 5;
        sb.push_back(e);
        g++;
      end
      if (g < n) @(negedge clk);
    end
    if (g < n) fail_now("grant_seq_wait");
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_empty();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    int   quiet;
    bit   got;
    exp_t e;
    int   ord_all[5];
    int   ord_13[5];

    tbl[0] = '{0, 32'd3,         32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 5, 1};
    tbl[1] = '{1, 32'd0,         32'd7,         64'h0,                   1'b0, 1, 0};
    tbl[2] = '{2, 32'd9,         32'd0,         64'h0,                   1'b0, 1, 0};
    tbl[3] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 5, 1};
    tbl[4] = '{2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 5, 1};
    tbl[5] = '{0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 5, 1};
    tbl[6] = '{2, 32'h1234_5678, 32'd2,         64'h0000_0000_2468_ACF0, 1'b0, 5, 1};
    tbl[7] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 5, 1};
    tbl[8] = '{3, 32'h0001_86A0, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFB_6C20, 1'b0, 5, 1};

    hop1[0] = 32'd2;        hop2[0] = 32'd3;         hprod[0] = 64'h0000_0000_0000_0006;
    hop1[1] = 32'hFFFF_FFFC; hop2[1] = 32'd5;        hprod[1] = 64'hFFFF_FFFF_FFFF_FFEC;
    hop1[2] = 32'h0001_0000; hop2[2] = 32'h0001_0000; hprod[2] = 64'h0000_0001_0000_0000;
    hop1[3] = 32'd7;        hop2[3] = 32'hFFFF_FFFF; hprod[3] = 64'hFFFF_FFFF_FFFF_FFF9;
    ord_all = '{0, 1, 2, 3, 0};

    // Reset values, then first grant exactly at the end of the drain period.
    repeat (3) @(negedge clk);
    chk_reset();
    resetn = 1'b1;
    rel = cyc;
    run_vec(tbl[0], acc);
    chk("first_grant_cycle", 64'(acc - rel), 64'd33);

    for (int i = 1; i < 9; i++) run_vec(tbl[i], acc);

    // Pointer now 0: all four held.
    grant_seq(4'b1111, 5, ord_all);

    // Single request from 1 moves the pointer to 2; then only 1 and 3 held.
    run_vec('{1, 32'd6, 32'd6, 64'd36, 1'b0, 5, 1}, acc);
    hop1[1] = 32'd11; hop2[1] = 32'd11;        hprod[1] = 64'h0000_0000_0000_0079;
    hop1[3] = 32'd13; hop2[3] = 32'hFFFF_FFFE; hprod[3] = 64'hFFFF_FFFF_FFFF_FFE6;
    ord_13 = '{3, 1, 0, 0, 0};
    grant_seq(4'b1010, 2, ord_13);

    // Response back-pressure: outputs hold and no further grant is issued.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_op1[31:0] = 32'd6;
    req_op2[31:0] = 32'd7;
    req_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (req_ready[0]) got = 1;
      else @(negedge clk);
    end
    if (!got) fail_now("stall_grant_wait");
    e = '{2'd0, 64'h2A, 1'b0, cyc, 0};
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    if (!got) fail_now("stall_rsp_wait");
    req_op1[2*32 +: 32] = 32'd3;
    req_op2[2*32 +: 32] = 32'd3;
    req_valid[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("stall_rsp_id", 64'(rsp_id), 64'h0);
      chk("stall_rsp_product", rsp_product, 64'h2A);
      chk("stall_no_grant", 64'(req_ready), 64'h0);
    end
    req_valid[2] = 1'b0;
    rsp_ready = 1'b1;
    wait_empty();

    // Reset asserted while waiting on the multiplier: result discarded.
    @(negedge clk);
    req_op1[2*32 +: 32] = 32'd5;
    req_op2[2*32 +: 32] = 32'd6;
    req_valid[2] = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (req_ready[2]) got = 1;
      else @(negedge clk);
    end
    if (!got) fail_now("rstwait_grant_wait");
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_wait_mult_op1", 64'(mult_op1), 64'd5);
    resetn = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    resetn = 1'b1;
    rel = cyc;
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || mult_begin) quiet++;
    end
    chk("drain_quiet", 64'(quiet), 64'h0);
    run_vec(tbl[0], acc);
    chk("redrain_first_grant", 64'(acc - rel), 64'd33);

`ifdef MULT_ARB_TIMEOUT_EN
    stub_dead = 1'b1;
    run_vec('{1, 32'd4, 32'd4, 64'h0, 1'b1, 42, 1}, acc);
    stub_dead = 1'b0;
    run_vec('{2, 32'd2, 32'd3, 64'd6, 1'b0, 5, 1}, acc);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
